// File: rtl/pc_seq_pkg.sv
// Shared definitions for the program-counter sequencer: control op encoding
// as issued by the decode/control unit.
package pc_seq_pkg;

  localparam int OP_W = 3;

  typedef enum logic [OP_W-1:0] {
    OP_NOP    = 3'd0,
    OP_JUMP   = 3'd1,
    OP_BRANCH = 3'd2,
    OP_CALL   = 3'd3,
    OP_RET    = 3'd4
  } op_e;

endpackage

// File: rtl/ret_stack.sv
// Return-address LIFO for pc_seq. The top entry is readable in the same cycle
// so RET can redirect the PC without an extra stall.
module ret_stack
  import pc_seq_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  localparam int DEPTH_W = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push,
  input  logic               pop,
  input  logic [WIDTH-1:0]   push_data,
  output logic [WIDTH-1:0]   top,
  output logic [DEPTH_W-1:0] depth,
  output logic               full,
  output logic               empty
);

  // Storage is rounded up to a power of two so the pointer slice indexes it exactly.
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0]   mem [2**IDX_W];
  logic [DEPTH_W-1:0] depth_reg;
  logic [DEPTH_W-1:0] depth_next;
  logic [DEPTH_W-1:0] top_ptr;
  logic               do_push;
  logic               do_pop;

  assign full    = (depth_reg == DEPTH_W'(DEPTH));
  assign empty   = (depth_reg == '0);
  assign do_push = push && !full;
  assign do_pop  = pop && !empty && !push;
  assign top_ptr = depth_reg - DEPTH_W'(1);
  assign top     = mem[top_ptr[IDX_W-1:0]];
  assign depth   = depth_reg;

  always_comb begin
    depth_next = depth_reg;
    if (do_push) begin
      depth_next = depth_reg + DEPTH_W'(1);
    end else if (do_pop) begin
      depth_next = depth_reg - DEPTH_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      depth_reg <= '0;
    end else begin
      depth_reg <= depth_next;
    end
  end

  // Contents are don't-care after reset, so the array carries no reset.
  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[depth_reg[IDX_W-1:0]] <= push_data;
    end
  end

endmodule

// File: rtl/pc_seq.sv
// Program-counter sequencer: step/jump/branch/call/return with a return-address
// stack; drives the instruction-memory address from a registered pc.
module pc_seq
  import pc_seq_pkg::*;
#(
  parameter int ADDR_W     = 8,
  parameter int OFF_W      = 8,
  parameter int STEP       = 1,
  parameter int DEPTH      = 4,
  parameter bit EDGE_INCR  = 1'b1,
  parameter int RESET_ADDR = 0,
  localparam int DEPTH_W   = $clog2(DEPTH + 1)
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               incr,
  input  logic               op_valid,
  input  logic [OP_W-1:0]    op,
  input  logic [ADDR_W-1:0]  target,
  input  logic [OFF_W-1:0]   offset,
  output logic [ADDR_W-1:0]  pc,
  output logic [DEPTH_W-1:0] depth,
  output logic               stack_full,
  output logic               stack_empty,
  output logic               err
);

  logic [ADDR_W-1:0] pc_reg;
  logic [ADDR_W-1:0] pc_next;
  logic              incr_prev_reg;
  logic              err_reg;
  logic              err_next;
  logic              advance;
  logic              push;
  logic              pop;
  logic [ADDR_W-1:0] pc_step;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] stack_top;

  assign advance = EDGE_INCR ? (incr && !incr_prev_reg) : incr;
  assign pc_step = pc_reg + ADDR_W'(STEP);
  assign off_ext = ADDR_W'($signed(offset));

  // A recognised op always wins over the advance event and consumes it,
  // even when it fails (CALL on full / RET on empty leave pc untouched).
  always_comb begin
    pc_next  = advance ? pc_step : pc_reg;
    err_next = 1'b0;
    push     = 1'b0;
    pop      = 1'b0;
    if (op_valid) begin
      case (op)
        OP_JUMP:   pc_next = target;
        OP_BRANCH: pc_next = pc_reg + off_ext;
        OP_CALL: begin
          if (stack_full) begin
            pc_next  = pc_reg;
            err_next = 1'b1;
          end else begin
            pc_next = target;
            push    = 1'b1;
          end
        end
        OP_RET: begin
          if (stack_empty) begin
            pc_next  = pc_reg;
            err_next = 1'b1;
          end else begin
            pc_next = stack_top;
            pop     = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_reg        <= ADDR_W'(RESET_ADDR);
      incr_prev_reg <= 1'b0;
      err_reg       <= 1'b0;
    end else begin
      pc_reg        <= pc_next;
      incr_prev_reg <= incr;
      err_reg       <= err_next;
    end
  end

  ret_stack #(
    .WIDTH (ADDR_W),
    .DEPTH (DEPTH)
  ) u_ret_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .pop       (pop),
    .push_data (pc_step),
    .top       (stack_top),
    .depth     (depth),
    .full      (stack_full),
    .empty     (stack_empty)
  );

  assign pc  = pc_reg;
  assign err = err_reg;

endmodule
